// File: rtl/player_ctrl_if.sv
// Joystick-to-renderer bundle: frame strobe and joystick levels in, sprite/bullet coordinates out.
interface player_ctrl_if;
   logic       i_frame;
   logic       i_up;
   logic       i_down;
   logic       i_left;
   logic       i_right;
   logic       i_fire;
   logic [9:0] o_x;
   logic [9:0] o_y;
   logic       o_bullet_valid;
   logic [9:0] o_bullet_x;
   logic [9:0] o_bullet_y;
   logic       o_fire_pulse;

   modport slave (
      input  i_frame, i_up, i_down, i_left, i_right, i_fire,
      output o_x, o_y, o_bullet_valid, o_bullet_x, o_bullet_y, o_fire_pulse
   );

   modport master (
      output i_frame, i_up, i_down, i_left, i_right, i_fire,
      input  o_x, o_y, o_bullet_valid, o_bullet_x, o_bullet_y, o_fire_pulse
   );
endinterface

// File: rtl/player_ctrl.sv
// Per-frame player motion with edge clamping plus a single-bullet IDLE/FLY shot machine.
// Inputs sampled on the i_frame edge; results visible one cycle later, held until the next frame.
module player_ctrl #(
   parameter int X_MAX       = 624,
   parameter int Y_MAX       = 464,
   parameter int X_INIT      = 312,
   parameter int Y_INIT      = 432,
   parameter int STEP        = 2,
   parameter int BULLET_STEP = 8,
   parameter int COOLDOWN    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   player_ctrl_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, FLY = 1'b1} state_t;

   localparam int CW = ($clog2(COOLDOWN + 1) > 4) ? $clog2(COOLDOWN + 1) : 4;
   // Counter holds frames still to wait after the launch frame, so the next
   // launch lands exactly COOLDOWN frames after the previous one.
   localparam logic [CW-1:0] COOL_LOAD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

   state_t        r_state, w_state_nxt;
   logic [9:0]    r_x, r_y, r_bx, r_by;
   logic [9:0]    w_x_nxt, w_y_nxt, w_bx_nxt, w_by_nxt;
   logic [CW-1:0] r_cool, w_cool_nxt;
   logic          r_fire_pulse, w_fire_nxt;
   logic [10:0]   w_x_dec, w_x_inc, w_y_dec, w_y_inc;
   logic          w_launch;

   assign w_x_dec = {1'b0, r_x} - 11'(STEP);
   assign w_x_inc = {1'b0, r_x} + 11'(STEP);
   assign w_y_dec = {1'b0, r_y} - 11'(STEP);
   assign w_y_inc = {1'b0, r_y} + 11'(STEP);

   assign w_launch = bus.i_frame && (r_state == IDLE) && bus.i_fire && (r_cool == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_bx_nxt    = r_bx;
      w_by_nxt    = r_by;
      w_cool_nxt  = r_cool;
      w_fire_nxt  = 1'b0;
      if (bus.i_frame) begin
         // Bit 10 of the decrement flags an underflow below zero.
         if (bus.i_left && !bus.i_right)
            w_x_nxt = w_x_dec[10] ? 10'd0 : w_x_dec[9:0];
         else if (bus.i_right && !bus.i_left)
            w_x_nxt = (w_x_inc > 11'(X_MAX)) ? 10'(X_MAX) : w_x_inc[9:0];
         if (bus.i_up && !bus.i_down)
            w_y_nxt = w_y_dec[10] ? 10'd0 : w_y_dec[9:0];
         else if (bus.i_down && !bus.i_up)
            w_y_nxt = (w_y_inc > 11'(Y_MAX)) ? 10'(Y_MAX) : w_y_inc[9:0];

         if (r_cool != '0)
            w_cool_nxt = r_cool - 1'b1;

         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  w_state_nxt = FLY;
                  w_bx_nxt    = r_x + 10'd6;
                  w_by_nxt    = r_y;
                  w_cool_nxt  = COOL_LOAD;
                  w_fire_nxt  = 1'b1;
               end
            end
            FLY: begin
               if (r_by >= 10'(BULLET_STEP))
                  w_by_nxt = r_by - 10'(BULLET_STEP);
               else
                  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_x          <= 10'(X_INIT);
         r_y          <= 10'(Y_INIT);
         r_bx         <= '0;
         r_by         <= '0;
         r_cool       <= '0;
         r_fire_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_x          <= w_x_nxt;
         r_y          <= w_y_nxt;
         r_bx         <= w_bx_nxt;
         r_by         <= w_by_nxt;
         r_cool       <= w_cool_nxt;
         r_fire_pulse <= w_fire_nxt;
      end
   end

   assign bus.o_x            = r_x;
   assign bus.o_y            = r_y;
   assign bus.o_bullet_valid = (r_state == FLY);
   assign bus.o_bullet_x     = r_bx;
   assign bus.o_bullet_y     = r_by;
   assign bus.o_fire_pulse   = r_fire_pulse;

endmodule
